// File: rtl/ysyx_25040111_issue_ctl.sv
// Single-entry issue stage with a GPR scoreboard: holds one decoded instruction and
// issues it once its sources and destination are free and the pending-write limit allows it.
module ysyx_25040111_issue_ctl #(
    parameter int unsigned MAX_PEND = 4
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,

    output logic       iss_valid,
    input  logic       iss_ready,
    output logic [4:0] iss_rs1,
    output logic [4:0] iss_rs2,
    output logic [4:0] iss_rd,

    input  logic       wb_valid,
    input  logic [4:0] wb_rd,

    input  logic       flush,
    output logic       stall,
    output logic [2:0] pend_cnt
);

    localparam logic [2:0] PendMax = 3'(MAX_PEND);

    logic        full_q, full_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] busy_q, busy_d;
    logic [2:0]  pend_q, pend_d;

    logic [31:0] busy_eff;
    logic [2:0]  pend_eff;
    logic        wb_hit;
    logic        hazard;
    logic        limit;
    logic        issue_ok;
    logic        issue;
    logic        accept;
    logic        rd_nz;

    assign rd_nz = (rd_q != 5'd0);

    // Writeback releases its register in the same cycle, so a waiting consumer can issue
    // without an extra bubble.
    always_comb begin
        wb_hit   = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
        busy_eff = busy_q;
        if (wb_valid) begin
            busy_eff[wb_rd] = 1'b0;
        end
        busy_eff[0] = 1'b0;
        pend_eff    = pend_q - {2'b00, wb_hit};
    end

    always_comb begin
        hazard   = busy_eff[rs1_q] | busy_eff[rs2_q] | busy_eff[rd_q];
        limit    = rd_nz && (pend_eff == PendMax);
        issue_ok = full_q && !hazard && !limit && !flush;
        issue    = issue_ok && iss_ready;
        accept   = dec_valid && !flush && (!full_q || issue);
    end

    assign iss_valid = issue_ok;
    assign stall     = full_q && !flush && (hazard || limit);
    assign dec_ready = !flush && (!full_q || issue);
    assign iss_rs1   = rs1_q;
    assign iss_rs2   = rs2_q;
    assign iss_rd    = rd_q;
    assign pend_cnt  = pend_q;

    always_comb begin
        full_d = full_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        rd_d   = rd_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
            rs1_d  = dec_rs1;
            rs2_d  = dec_rs2;
            rd_d   = dec_rd;
        end else if (issue) begin
            full_d = 1'b0;
        end
    end

    // Issue set is applied after the writeback clear so that set wins on the same register.
    always_comb begin
        busy_d = busy_eff;
        pend_d = pend_eff;
        if (issue && rd_nz) begin
            busy_d[rd_q] = 1'b1;
            pend_d       = pend_eff + 3'd1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            rs1_q  <= 5'd0;
            rs2_q  <= 5'd0;
            rd_q   <= 5'd0;
            busy_q <= 32'd0;
            pend_q <= 3'd0;
        end else begin
            full_q <= full_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_issue_ctl.sv
// Directed bench for ysyx_25040111_issue_ctl: hand-computed expectations per cycle.
module tb_ysyx_25040111_issue_ctl;

    logic       clock;
    logic       reset;
    logic       dec_valid;
    logic       dec_ready;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       iss_valid;
    logic       iss_ready;
    logic [4:0] iss_rs1, iss_rs2, iss_rd;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic       stall;
    logic [2:0] pend_cnt;

    int n_vec = 0;
    int n_err = 0;

    ysyx_25040111_issue_ctl #(.MAX_PEND(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        dec_valid = 1'b1;
        dec_rs1   = rs1;
        dec_rs2   = rs2;
        dec_rd    = rd;
    endtask

    task automatic no_dec();
        dec_valid = 1'b0;
        dec_rs1   = 5'd0;
        dec_rs2   = 5'd0;
        dec_rd    = 5'd0;
    endtask

    task automatic wb(input logic v, input logic [4:0] r);
        wb_valid = v;
        wb_rd    = r;
    endtask

    initial begin
        reset = 1'b0;
        no_dec();
        iss_ready = 1'b0;
        wb(1'b0, 5'd0);
        flush = 1'b0;

        #12;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_dec_ready", dec_ready, 1);
        check("rst_pend", pend_cnt, 0);
        check("rst_iss_rd", iss_rd, 0);
        #10 reset = 1'b1;
        tick();

        // Reset mid-operation: rd=5 in flight, consumer of x5 held.
        dec(0, 0, 5); tick();
        no_dec(); iss_ready = 1'b1; #1;
        check("mid_first_valid", iss_valid, 1);
        tick();
        dec(5, 0, 0); iss_ready = 1'b0; tick();
        no_dec(); #1;
        check("mid_stall", stall, 1);
        check("mid_pend", pend_cnt, 1);
        #2 reset = 1'b0; #1;
        check("mid_rst_iss_valid", iss_valid, 0);
        check("mid_rst_pend", pend_cnt, 0);
        check("mid_rst_dec_ready", dec_ready, 1);
        tick(); tick();
        #2 reset = 1'b1;
        tick();
        dec(5, 0, 0); tick();
        no_dec(); #1;
        check("post_rst_stall", stall, 0);
        check("post_rst_valid", iss_valid, 1);
        iss_ready = 1'b1; tick();
        check("post_rst_pend", pend_cnt, 0);

        // Independent stream rd=1,2,3.
        dec(0, 0, 1); tick();
        dec(0, 0, 2); #1;
        check("ind_rd1", iss_rd, 1);
        check("ind_v1", iss_valid, 1);
        check("ind_ready1", dec_ready, 1);
        tick();
        dec(0, 0, 3); #1;
        check("ind_rd2", iss_rd, 2);
        check("ind_pend1", pend_cnt, 1);
        check("ind_stall2", stall, 0);
        tick();
        no_dec(); #1;
        check("ind_rd3", iss_rd, 3);
        check("ind_v3", iss_valid, 1);
        check("ind_pend2", pend_cnt, 2);
        tick();
        check("ind_pend3", pend_cnt, 3);
        check("ind_empty", iss_valid, 0);
        check("ind_stall_end", stall, 0);
        wb(1, 1); tick();
        wb(1, 2); tick();
        wb(1, 3); tick();
        wb(0, 0); #1;
        check("ind_drain", pend_cnt, 0);

        // RAW on x5 with writeback bypass.
        dec(0, 0, 5); tick();
        dec(5, 0, 0); tick();
        no_dec(); #1;
        check("raw_stall", stall, 1);
        check("raw_blocked", iss_valid, 0);
        check("raw_pend", pend_cnt, 1);
        tick();
        check("raw_stall_hold", stall, 1);
        check("raw_hold_rs1", iss_rs1, 5);
        wb(1, 5); #1;
        check("raw_bypass_valid", iss_valid, 1);
        check("raw_bypass_stall", stall, 0);
        tick();
        wb(0, 0); #1;
        check("raw_pend_done", pend_cnt, 0);
        check("raw_empty", iss_valid, 0);
        dec(5, 0, 0); tick();
        no_dec(); #1;
        check("raw_cleared", stall, 0);
        tick();

        // WAW on x7 with same-cycle set/clear.
        dec(0, 0, 7); tick();
        dec(0, 0, 7); tick();
        no_dec(); #1;
        check("waw_stall", stall, 1);
        wb(1, 7); #1;
        check("waw_bypass", iss_valid, 1);
        tick();
        wb(0, 0); #1;
        check("waw_pend", pend_cnt, 1);
        dec(7, 0, 0); tick();
        no_dec(); #1;
        check("waw_still_busy", stall, 1);
        wb(1, 7); tick();
        wb(0, 0); #1;
        check("waw_drain", pend_cnt, 0);

        // Pending limit.
        dec(0, 0, 1); tick();
        dec(0, 0, 2); tick();
        dec(0, 0, 3); tick();
        dec(0, 0, 4); tick();
        dec(0, 0, 6); tick();
        no_dec(); #1;
        check("lim_pend", pend_cnt, 4);
        check("lim_stall", stall, 1);
        check("lim_blocked", iss_valid, 0);
        check("lim_dec_ready", dec_ready, 0);
        wb(1, 2); #1;
        check("lim_release", iss_valid, 1);
        check("lim_release_stall", stall, 0);
        tick();
        wb(0, 0); #1;
        check("lim_pend_net", pend_cnt, 4);
        dec(0, 0, 0); tick();
        no_dec(); #1;
        check("lim_rd0_valid", iss_valid, 1);
        check("lim_rd0_stall", stall, 0);
        tick();
        check("lim_rd0_pend", pend_cnt, 4);

        // Ignored writebacks and flush.
        wb(1, 0); tick();
        wb(1, 2); tick();
        wb(0, 0); #1;
        check("wb_ignored", pend_cnt, 4);
        dec(3, 0, 0); tick();
        no_dec(); #1;
        check("fl_pre_stall", stall, 1);
        flush = 1'b1; dec(0, 0, 0); #1;
        check("fl_iss_valid", iss_valid, 0);
        check("fl_dec_ready", dec_ready, 0);
        check("fl_stall", stall, 0);
        tick();
        flush = 1'b0; no_dec(); #1;
        check("fl_empty", iss_valid, 0);
        check("fl_empty_stall", stall, 0);
        check("fl_dec_ready_after", dec_ready, 1);
        check("fl_pend", pend_cnt, 4);
        dec(3, 0, 0); tick();
        no_dec(); #1;
        check("fl_busy_kept", stall, 1);
        wb(1, 3); tick();
        wb(1, 1); tick();
        wb(1, 4); tick();
        wb(1, 6); tick();
        wb(0, 0); #1;
        check("final_pend", pend_cnt, 0);
        check("final_empty", iss_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
